// File: rtl/tank_explosion_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tank_explosion_sprite_fetch
// Description : Plays a multi-frame explosion animation at a latched tank
//               position and fetches the per-pixel colour index from an
//               external synchronous sprite ROM for the explosion palette.
// Revision    : 1.0 - initial release
// ============================================================================
module tank_explosion_sprite_fetch #(
    parameter int          SPR_W      = 32,
    parameter int          SPR_H      = 32,
    parameter int          NUM_FRAMES = 4,
    parameter int          FRAME_HOLD = 6,
    parameter int          ROM_LAT    = 1,
    parameter logic [3:0]  TRANSP_IDX = 4'h1,
    localparam int         ADDR_W     = $clog2(NUM_FRAMES*SPR_W*SPR_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              trigger,
    input  logic [9:0]        tank_x,
    input  logic [9:0]        tank_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        palette_index,
    output logic              sprite_on,
    output logic              anim_busy,
    output logic              anim_done
);

    localparam int C_FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int C_HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [0:0]           c_idle       = 1'b0;
    localparam logic [0:0]           c_play       = 1'b1;
    localparam logic [C_HOLD_W-1:0]  c_hold_max   = C_HOLD_W'(FRAME_HOLD - 1);
    localparam logic [C_FRAME_W-1:0] c_last_frame = C_FRAME_W'(NUM_FRAMES - 1);

    logic [0:0]           r_state, w_state_nxt;
    logic [C_FRAME_W-1:0] r_frame, w_frame_nxt;
    logic [C_HOLD_W-1:0]  r_hold,  w_hold_nxt;
    logic                 w_latch;
    logic                 w_done_nxt;
    logic [9:0]           r_x_lat, r_y_lat;
    logic                 r_done;

    logic [10:0]          w_dx, w_dy;
    logic                 w_hit;
    logic [ADDR_W-1:0]    w_addr;
    logic [ADDR_W-1:0]    r_rom_addr;
    logic [ROM_LAT:0]     r_hit_sr;
    logic [3:0]           r_pal;
    logic                 r_on;
    logic                 w_on;

    // Animation state, frame/hold counters and latched sprite position.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_idle;
            r_frame <= '0;
            r_hold  <= '0;
            r_x_lat <= '0;
            r_y_lat <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_frame <= w_frame_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_x_lat <= tank_x;
                r_y_lat <= tank_y;
            end
        end
    end

    // Next-state logic: frames advance only on vblank so a frame never tears.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_hold_nxt  = r_hold;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_idle: begin
                if (trigger) begin
                    w_state_nxt = c_play;
                    w_frame_nxt = '0;
                    w_hold_nxt  = '0;
                    w_latch     = 1'b1;
                end
            end
            c_play: begin
                if (frame_start) begin
                    if (r_hold < c_hold_max) begin
                        w_hold_nxt = r_hold + 1'b1;
                    end else begin
                        w_hold_nxt = '0;
                        if (r_frame == c_last_frame) begin
                            w_state_nxt = c_idle;
                            w_frame_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_frame_nxt = r_frame + 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Offsets in 11 bits: bit 10 set means the pixel lies left of / above the sprite.
    assign w_dx  = {1'b0, DrawX} - {1'b0, r_x_lat};
    assign w_dy  = {1'b0, DrawY} - {1'b0, r_y_lat};
    assign w_hit = (r_state == c_play) & pix_valid &
                   ~w_dx[10] & (w_dx < 11'(SPR_W)) &
                   ~w_dy[10] & (w_dy < 11'(SPR_H));

    assign w_addr = ADDR_W'(r_frame) * ADDR_W'(SPR_W*SPR_H)
                  + ADDR_W'(w_dy) * ADDR_W'(SPR_W)
                  + ADDR_W'(w_dx);

    // Address stage plus hit delay line matched to the ROM read latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rom_addr <= '0;
            r_hit_sr   <= '0;
        end else begin
            r_rom_addr <= w_hit ? w_addr : '0;
            r_hit_sr   <= {r_hit_sr[ROM_LAT-1:0], w_hit};
        end
    end

    assign w_on = r_hit_sr[ROM_LAT] & (rom_q != TRANSP_IDX);

    // Output stage: register the colour index with its opaque-hit flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pal <= 4'h0;
            r_on  <= 1'b0;
        end else begin
            r_pal <= w_on ? rom_q : 4'h0;
            r_on  <= w_on;
        end
    end

    assign rom_addr      = r_rom_addr;
    assign palette_index = r_pal;
    assign sprite_on     = r_on;
    assign anim_busy     = (r_state == c_play);
    assign anim_done     = r_done;

endmodule
`default_nettype wire
